// File: rtl/snake_body_tracker.sv
// Snake body tracker: keeps the segment list on the 40x30 grid.
// It advances the snake one cell per move_tick, grows the snake on add_cube,
// and shrinks it on reduce_length.
// It detects wall and self collisions (sticky game_over) and answers
// registered per-cell occupancy queries for the renderer.
//
// Handshake: there is no valid/ready flow control. move_tick, add_cube and
// reduce_length are one-cycle pulses that are sampled on each rising clk edge.
// query_x/query_y are sampled every cycle, and query_hit/query_is_head answer
// them one cycle later.
module snake_body_tracker #(
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 3,
  parameter int START_X   = 20,
  parameter int START_Y   = 15,
  parameter int WALL_X_LO = 1,
  parameter int WALL_X_HI = 38,
  parameter int WALL_Y_LO = 1,
  parameter int WALL_Y_HI = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic [1:0] dir,
  input  logic       add_cube,
  input  logic       reduce_length,
  input  logic [5:0] query_x,
  input  logic [4:0] query_y,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       query_hit,
  output logic       query_is_head,
  output logic       game_over
);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

  localparam logic [5:0] X_LO  = 6'(WALL_X_LO);
  localparam logic [5:0] X_HI  = 6'(WALL_X_HI);
  localparam logic [4:0] Y_LO  = 5'(WALL_Y_LO);
  localparam logic [4:0] Y_HI  = 5'(WALL_Y_HI);
  localparam logic [4:0] MAX_L = 5'(MAX_LEN);

  state_t     state, state_next;
  logic [5:0] seg_x [MAX_LEN];
  logic [4:0] seg_y [MAX_LEN];
  logic [4:0] len_q, len_next;
  logic [1:0] cur_dir, eff_dir;
  logic [1:0] pending_grow, pending_next;
  logic [5:0] nx;
  logic [4:0] ny;
  logic [4:0] self_lim;
  logic       grow_now, wall_hit, self_hit, collide, do_move;
  logic       q_hit_c, q_head_c;

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign length    = len_q;
  assign game_over = (state == DEAD);

  // Next head cell, collision detection and FSM next-state.
  always_comb begin
    state_next = state;
    eff_dir    = cur_dir;
    nx         = seg_x[0];
    ny         = seg_y[0];
    self_hit   = 1'b0;
    // Opposite directions differ only in bit 0 (up/down, left/right).
    if ((dir ^ cur_dir) != 2'b01) eff_dir = dir;
    case (eff_dir)
      2'b00:   ny = seg_y[0] - 5'd1;
      2'b01:   ny = seg_y[0] + 5'd1;
      2'b10:   nx = seg_x[0] - 6'd1;
      default: nx = seg_x[0] + 6'd1;
    endcase
    grow_now = (pending_grow != 2'd0) && (len_q < MAX_L);
    wall_hit = (nx < X_LO) || (nx > X_HI) || (ny < Y_LO) || (ny > Y_HI);
    // The tail cell vacates on this step only when the snake is not growing.
    self_lim = grow_now ? len_q : (len_q - 5'd1);
    for (int j = 0; j < MAX_LEN; j++) begin
      if ((5'(j) < self_lim) && (seg_x[j] == nx) && (seg_y[j] == ny)) self_hit = 1'b1;
    end
    collide = wall_hit || self_hit;
    do_move = (state == RUN) && move_tick && !collide;
    if ((state == RUN) && move_tick && collide) state_next = DEAD;
  end

  // Length and pending-growth bookkeeping. add_cube lands after this tick's grow decision.
  always_comb begin
    pending_next = pending_grow;
    len_next     = len_q;
    if (move_tick) begin
      if (!collide && grow_now)                              pending_next = pending_grow - 2'd1;
      else if ((pending_grow != 2'd0) && (len_q == MAX_L))   pending_next = 2'd0;
    end
    if (add_cube && (pending_next != 2'd3)) pending_next = pending_next + 2'd1;
    if (do_move && grow_now) len_next = len_next + 5'd1;
    // add_cube takes priority over a simultaneous reduce_length.
    if (reduce_length && !add_cube && (len_q > 5'd1)) len_next = len_next - 5'd1;
  end

  // Occupancy lookup against the current active segments.
  always_comb begin
    q_hit_c  = 1'b0;
    q_head_c = (seg_x[0] == query_x) && (seg_y[0] == query_y);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (seg_x[i] == query_x) && (seg_y[i] == query_y)) q_hit_c = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Segment storage, direction, length and growth counter; all are frozen while DEAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(START_X - i);
        seg_y[i] <= 5'(START_Y);
      end
      len_q        <= 5'(INIT_LEN);
      cur_dir      <= 2'b11;
      pending_grow <= 2'd0;
    end else if (state == RUN) begin
      if (move_tick) cur_dir <= eff_dir;
      if (do_move) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nx;
        seg_y[0] <= ny;
      end
      len_q        <= len_next;
      pending_grow <= pending_next;
    end
  end

  // Registered query outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      query_hit     <= 1'b0;
      query_is_head <= 1'b0;
    end else begin
      query_hit     <= q_hit_c;
      query_is_head <= q_head_c;
    end
  end

endmodule
